// File: rtl/conn_topk_sorter.sv
// Top-K connection sorter: keeps the K smallest-distance connections in a sorted
// register array and drains them in ascending order once the producer is done.
package conn_topk_pkg;
    typedef struct packed {
        logic [31:0] distance;
        logic [15:0] pointa;
        logic [15:0] pointb;
    } conn_t;
endpackage

// state  | meaning
// FILL   | accept and insert connections, wait for done_in
// FLUSH  | keep inserting for FLUSH_CYC cycles to absorb producer lag
// DRAIN  | emit retained entries in ascending order over valid/ready
// DONE   | finished; holds until reset
module conn_topk_sorter
    import conn_topk_pkg::*;
#(
    parameter int K         = 1000,
    parameter int FLUSH_CYC = 4,
    parameter int CNT_W     = 32,
    localparam int IDX_W    = (K > 1) ? $clog2(K) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  conn_t            conn_in,
    input  logic             conn_in_vld,
    input  logic             done_in,
    output conn_t            out_conn,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] accepted_cnt,
    output logic             overflow_err,
    output logic             done_out
);
    localparam int FC_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic [1:0] {S_FILL, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [FC_W-1:0] flush_cnt;
    conn_t           ent    [K];
    conn_t           ent_dn [K];
    conn_t           ent_up [K];
    logic [K-1:0]    ent_vld, vld_dn, vld_up, lt, lt_dn, up, take;
    logic            ins, hs;

    assign ins      = conn_in_vld && (state == S_FILL || state == S_FLUSH);
    assign hs       = (state == S_DRAIN) && out_vld && out_rdy;
    assign done_out = (state == S_DONE);

    // Neighbour views so every slot sees in-range values at the array ends
    for (genvar g = 0; g < K; g++) begin : g_slot
        assign lt[g] = conn_in.distance < ent[g].distance;
        if (g == 0) begin : g_head
            assign ent_dn[g] = '0;
            assign vld_dn[g] = 1'b0;
            assign lt_dn[g]  = 1'b0;
            assign take[g]   = lt[g] || !ent_vld[g];
        end else begin : g_body
            assign ent_dn[g] = ent[g-1];
            assign vld_dn[g] = ent_vld[g-1];
            assign lt_dn[g]  = lt[g-1];
            assign take[g]   = (lt[g] || !ent_vld[g]) && ent_vld[g-1] && !lt[g-1];
        end
        if (g == K - 1) begin : g_tail
            assign ent_up[g] = '0;
            assign vld_up[g] = 1'b0;
        end else begin : g_inner
            assign ent_up[g] = ent[g+1];
            assign vld_up[g] = ent_vld[g+1];
        end
        assign up[g] = vld_dn[g] && lt_dn[g];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_vld <= '0;
        end else begin
            for (int i = 0; i < K; i++) begin
                if (ins) begin
                    if (up[i]) begin
                        ent[i]     <= ent_dn[i];
                        ent_vld[i] <= 1'b1;
                    end else if (take[i]) begin
                        ent[i]     <= conn_in;
                        ent_vld[i] <= 1'b1;
                    end
                end else if (hs) begin
                    ent[i]     <= ent_up[i];
                    ent_vld[i] <= vld_up[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FILL;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FILL:  if (done_in) state_nxt = S_FLUSH;
            // An insert on the final flush cycle still counts as content to drain
            S_FLUSH: if (flush_cnt == '0) state_nxt = (ent_vld[0] || ins) ? S_DRAIN : S_DONE;
            S_DRAIN: if (hs && out_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                              flush_cnt <= '0;
        else if (state == S_FILL && done_in)     flush_cnt <= FC_W'(FLUSH_CYC - 1);
        else if (state == S_FLUSH && flush_cnt != '0) flush_cnt <= flush_cnt - FC_W'(1);
    end

    // Output registers load the head the array will hold after this cycle's shift
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
            out_idx  <= '0;
            out_conn <= '0;
        end else if (state == S_DRAIN) begin
            if (hs) begin
                out_vld  <= vld_up[0];
                out_conn <= ent_up[0];
                out_last <= vld_up[0] && !vld_up[1];
                out_idx  <= out_idx + IDX_W'(1);
            end else begin
                out_vld  <= ent_vld[0];
                out_conn <= ent[0];
                out_last <= ent_vld[0] && !vld_up[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            accepted_cnt <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (ins && accepted_cnt != '1) accepted_cnt <= accepted_cnt + CNT_W'(1);
            if (conn_in_vld && (state == S_DRAIN || state == S_DONE)) overflow_err <= 1'b1;
        end
    end
endmodule

// File: doc/conn_topk_sorter.md
Name: conn_topk_sorter

Overview:
- Receiving end of the conn stream (conn_t: distance, pointa, pointb) produced by the distance calculator.
- Retains the K smallest-distance connections in a sorted register array, inserting one connection per cycle with no backpressure.
- After the producer signals done, drains the retained entries in ascending distance order over a valid/ready stream to the downstream circuit-merge logic.

Parameters:
- K, 1000, number of smallest connections retained and emitted.
- FLUSH_CYC, 4, cycles to keep accepting input after done_in is first seen; covers producer pipeline lag.
- CNT_W, 32, width of the accepted-connection counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; synchronous, active-low.
- conn_in  input  conn_t  incoming connection.
- conn_in_vld  input  1  conn_in valid. No ready; must be accepted every cycle in FILL/FLUSH.
- done_in  input  1  producer finished; level, may stay high.
- out_conn  output  conn_t  emitted connection, ascending distance.
- out_vld  output  1  out_conn valid.
- out_rdy  input  1  downstream ready.
- out_last  output  1  high with the final emitted entry.
- out_idx  output  $clog2(K)  rank of out_conn, 0 = smallest.
- accepted_cnt  output  CNT_W  connections received in FILL/FLUSH; saturates at all-ones.
- overflow_err  output  1  sticky; conn_in_vld seen in DRAIN or DONE.
- done_out  output  1  high in DONE.

Behaviour:
- Storage:
  - Arrays ent[0..K-1] of conn_t, each with a valid bit.
  - Invariant: valid entries are contiguous from index 0, and ent[i].distance <= ent[i+1].distance.
- Reset values:
  - out_vld=0, out_last=0, out_idx=0, out_conn=0.
  - accepted_cnt=0, overflow_err=0, done_out=0.
  - All valid bits 0; state FILL.
- Reset mid-operation, in any state: returns to the reset values above on the next edge. Partial drains are discarded.
- States:
  - FILL: insert on conn_in_vld. Go to FLUSH on the first cycle done_in=1. A conn_in_vld in that same cycle is still inserted.
  - FLUSH: insert on conn_in_vld. After FLUSH_CYC cycles, go to DRAIN if any entry is valid, else go to DONE.
  - DRAIN: out_vld=1 whenever ent[0] is valid. On out_vld&&out_rdy, all entries shift down one (ent[i]<=ent[i+1], top valid bit cleared) and out_idx increments. Go to DONE on the handshake with out_last=1.
  - DONE: done_out=1. Holds until reset; done_in is ignored.
- Insertion, single cycle; the result is visible at the array the next cycle. Let n = new distance. For each slot i:
  - Shift up (ent[i]<=ent[i-1]) if ent[i-1] is valid and n < ent[i-1].distance.
  - Take new (ent[i]<=conn_in) if n < ent[i].distance or ent[i] is invalid, and additionally i==0, or ent[i-1] is valid with n >= ent[i-1].distance.
  - Otherwise hold.
  - Ties: a new entry goes after existing equal distances (stable, arrival order).
  - Array full and n >= ent[K-1].distance: new entry dropped, still counted in accepted_cnt.
  - Array full and n is smaller: ent[K-1] is evicted.
- Comparisons: unsigned, full conn_t distance width.
- Output timing:
  - out_conn, out_idx and out_last are registered from ent[0] and the rank counter.
  - First out_vld is the cycle after entering DRAIN.
  - out_last=1 iff ent[1] is invalid while ent[0] is valid.
  - Number of beats = min(accepted, K).
  - Outputs stay stable while out_vld&&!out_rdy.
  - out_vld drops the cycle after the last handshake.
- Overflow: conn_in_vld in DRAIN or DONE does not modify the array and sets overflow_err until reset.
- accepted_cnt increments on every conn_in_vld in FILL/FLUSH and saturates, no wrap.

Test Plan:
- Basic ascending order (K=4): inputs dist 50,20,80,10,30 (pointa/pointb = 1..5), then done_in, out_rdy=1 -> outputs 10,20,30,50 with out_idx 0..3, out_last on 50. accepted_cnt=5, done_out=1 after the last beat.
- Tie ordering (K=4): dist 7(a=1),7(a=2),3(a=3),7(a=4) -> output 3(a=3),7(a=1),7(a=2),7(a=4).
- Underfill and empty (K=4): two inputs 9,4 -> two beats 4,9, out_last on 9. Zero inputs then done_in -> no out_vld, done_out=1 after FLUSH_CYC+1 cycles.
- Late arrivals: conn_in_vld with dist 1 at 1 and 3 cycles after done_in rises (FLUSH_CYC=4) -> both are emitted first. A conn_in_vld in DRAIN -> array unchanged, overflow_err=1.
- Backpressure: out_rdy toggled 1,0,0,1,... -> out_conn/out_idx held stable while stalled, no duplicated or skipped ranks.
- Reset mid-drain: assert rst_n=0 after two handshakes -> all outputs return to reset values next cycle. A subsequent fresh stream of 3 entries drains correctly from out_idx 0.
